// File: rtl/goal_detector.sv
// Hoop break-beam conditioner: sync, debounce and polarity-normalise the IR sensor,
// then emit one registered goal pulse per ball, flag a stuck beam and count goals.
module goal_detector #(
  parameter int unsigned SENSOR_ACTIVE_LOW = 1,
  parameter int unsigned DEB_CYCLES        = 100_000,
  parameter int unsigned HOLDOFF_CYCLES    = 25_000_000,
  parameter int unsigned STUCK_CYCLES      = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       en,
  input  logic       cnt_clr,
  output logic       goal,
  output logic       blocked,
  output logic       fault,
  output logic [7:0] goal_cnt
);

  localparam logic        POL   = (SENSOR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int unsigned DW    = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TMAX  = (HOLDOFF_CYCLES > STUCK_CYCLES) ? HOLDOFF_CYCLES : STUCK_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HIT     = 2'd1,
    S_HOLDOFF = 2'd2,
    S_STUCK   = 2'd3
  } state_e;

  logic          sync1_q;
  logic          blk_s_q;
  logic          blk_deb_q;
  logic [DW-1:0] deb_cnt_q;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          goal_q, goal_d;
  logic          fault_q, fault_d;
  logic [7:0]    cnt_q, cnt_d;

  // Front end: the sync flops reset to the normalised "clear" level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      blk_s_q   <= 1'b0;
      blk_deb_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= sensor ^ POL;
      blk_s_q <= sync1_q;
      if (blk_s_q != blk_deb_q) begin
        if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
          blk_deb_q <= blk_s_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      goal_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      goal_q  <= goal_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    goal_d  = 1'b0;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (blk_deb_q) begin
          state_d = S_HIT;
          tcnt_d  = '0;
          goal_d  = en;
        end
      end
      S_HIT: begin
        // A clear beam takes priority over the stuck timeout.
        if (!blk_deb_q) begin
          state_d = S_HOLDOFF;
          tcnt_d  = '0;
        end else if (tcnt_q == TW'(STUCK_CYCLES - 1)) begin
          state_d = S_STUCK;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_HOLDOFF: begin
        if (tcnt_q == TW'(HOLDOFF_CYCLES - 1)) begin
          state_d = blk_deb_q ? S_HIT : S_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_STUCK: begin
        if (!blk_deb_q) begin
          state_d = S_HOLDOFF;
          tcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
      end
    endcase
    fault_d = (state_d == S_STUCK);
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (goal_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign goal     = goal_q;
  assign blocked  = blk_deb_q;
  assign fault    = fault_q;
  assign goal_cnt = cnt_q;

endmodule

// File: tb/tb_goal_detector.sv
// Self-checking bench for goal_detector: directed scenarios plus randomized sensor
// traffic compared each cycle against a window/phase-based reference model.
module tb_goal_detector;

  localparam int DEB   = 4;
  localparam int HOLD  = 10;
  localparam int STUCK = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor;
  logic       en;
  logic       cnt_clr;
  logic       goal;
  logic       blocked;
  logic       fault;
  logic [7:0] goal_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int goals_seen = 0;

  goal_detector #(
    .SENSOR_ACTIVE_LOW(1),
    .DEB_CYCLES(DEB),
    .HOLDOFF_CYCLES(HOLD),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sensor(sensor),
    .en(en),
    .cnt_clr(cnt_clr),
    .goal(goal),
    .blocked(blocked),
    .fault(fault),
    .goal_cnt(goal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: blk_d flips once the last DEB synchronised samples all disagree
  // with it; the ball phase is tracked as elapsed-cycle counts per mode.
  typedef enum {MD_IDLE, MD_HIT, MD_HOLD, MD_STUCK} mode_t;
  mode_t mode;
  bit    m_s1, m_bs, m_bd, m_goal, m_fault;
  int    m_cnt, hit_n, hold_n;
  bit    win[$];

  task automatic m_reset();
    m_s1 = 0; m_bs = 0; m_bd = 0; m_goal = 0; m_fault = 0;
    m_cnt = 0; hit_n = 0; hold_n = 0; mode = MD_IDLE;
    win.delete();
  endtask

  task automatic model_step();
    bit all_other;
    m_goal = 0;
    case (mode)
      MD_IDLE:  if (m_bd) begin mode = MD_HIT; hit_n = 0; m_goal = en; end
      MD_HIT: begin
        hit_n++;
        if (!m_bd) begin mode = MD_HOLD; hold_n = 0; end
        else if (hit_n == STUCK) mode = MD_STUCK;
      end
      MD_HOLD: begin
        hold_n++;
        if (hold_n == HOLD) begin mode = m_bd ? MD_HIT : MD_IDLE; hit_n = 0; end
      end
      MD_STUCK: if (!m_bd) begin mode = MD_HOLD; hold_n = 0; end
    endcase
    m_fault = (mode == MD_STUCK);
    if (cnt_clr) m_cnt = 0;
    else if (m_goal && m_cnt < 255) m_cnt++;
    win.push_back(m_bs);
    if (win.size() > DEB) void'(win.pop_front());
    if (win.size() == DEB) begin
      all_other = 1;
      foreach (win[k]) if (win[k] == m_bd) all_other = 0;
      if (all_other) m_bd = !m_bd;
    end
    m_bs = m_s1;
    m_s1 = (sensor == 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) m_reset();
    else model_step();
    #1;
    if (goal === 1'b1) goals_seen++;
    check_eq("m_goal", goal, m_goal);
    check_eq("m_blocked", blocked, m_bd);
    check_eq("m_fault", fault, m_fault);
    check_eq("m_goal_cnt", goal_cnt, m_cnt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_blk(input bit b);
    sensor = b ? 1'b0 : 1'b1;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    int g0;
    bit blk_any;
    rst = 1'b0; sensor = 1'b1; en = 1'b1; cnt_clr = 1'b0;
    m_reset();
    ticks(3);
    check_eq("rst_goal", goal, 0);
    check_eq("rst_blocked", blocked, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_cnt", goal_cnt, 0);
    rst = 1'b1;
    ticks(5);

    // 1: latency of a clean block
    set_blk(1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq("t1_goal", goal, (i == 7) ? 1 : 0);
      check_eq("t1_blocked", blocked, (i >= 6) ? 1 : 0);
    end
    check_eq("t1_cnt", goal_cnt, 1);
    set_blk(0); ticks(40);

    // 2: short glitches never reach blk_d
    g0 = goals_seen; blk_any = 0;
    for (int i = 0; i < 10; i++) begin
      set_blk(1);
      for (int j = 0; j < 3; j++) begin tick(); blk_any |= blocked; end
      set_blk(0);
      for (int j = 0; j < 3; j++) begin tick(); blk_any |= blocked; end
    end
    check_eq("t2_goals", goals_seen - g0, 0);
    check_eq("t2_blocked", blk_any, 0);
    ticks(10);

    // 3: re-block inside holdoff gives no second pulse
    clr_cnt();
    g0 = goals_seen;
    set_blk(1); ticks(20); set_blk(0); ticks(5);
    set_blk(1); ticks(20); set_blk(0); ticks(30);
    set_blk(1); ticks(20); set_blk(0); ticks(30);
    check_eq("t3_goals", goals_seen - g0, 2);
    check_eq("t3_cnt", goal_cnt, 2);

    // 4: stuck beam
    g0 = goals_seen;
    set_blk(1);
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 56) check_eq("t4_fault_pre", fault, 0);
      if (i == 57) check_eq("t4_fault_set", fault, 1);
    end
    check_eq("t4_fault_hold", fault, 1);
    set_blk(0);
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 5) check_eq("t4_blk_still", blocked, 1);
      if (j == 6) begin
        check_eq("t4_blk_fall", blocked, 0);
        check_eq("t4_fault_at_fall", fault, 1);
      end
      if (j == 7) check_eq("t4_fault_drop", fault, 0);
    end
    ticks(30);
    check_eq("t4_goals", goals_seen - g0, 1);

    // 5: en low at detection, then cnt_clr coincident with a pulse
    clr_cnt();
    g0 = goals_seen;
    en = 1'b0; set_blk(1); ticks(10);
    en = 1'b1; ticks(10); set_blk(0); ticks(30);
    check_eq("t5_goals", goals_seen - g0, 0);
    check_eq("t5_cnt", goal_cnt, 0);
    set_blk(1); ticks(20); set_blk(0); ticks(30);
    check_eq("t5_cnt_one", goal_cnt, 1);
    set_blk(1); ticks(6);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check_eq("t5_clr_goal", goal, 1);
    check_eq("t5_clr_cnt", goal_cnt, 0);
    ticks(13); set_blk(0); ticks(30);

    // 6: async reset in HOLDOFF and in STUCK
    clr_cnt();
    for (int i = 0; i < 2; i++) begin set_blk(1); ticks(20); set_blk(0); ticks(30); end
    set_blk(1); ticks(20); set_blk(0); ticks(9);
    check_eq("t6_cnt_pre", goal_cnt, 3);
    #3 rst = 1'b0;
    #1;
    check_eq("t6_goal", goal, 0);
    check_eq("t6_blocked", blocked, 0);
    check_eq("t6_fault", fault, 0);
    check_eq("t6_cnt", goal_cnt, 0);
    m_reset();
    ticks(2); rst = 1'b1; ticks(5);
    set_blk(1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check_eq("t6_idle_goal", goal, 1);
    end
    ticks(60);
    check_eq("t6_stuck_fault", fault, 1);
    #3 rst = 1'b0;
    #1;
    check_eq("t6_stuck_blocked", blocked, 0);
    check_eq("t6_stuck_fault_rst", fault, 0);
    m_reset();
    set_blk(0); ticks(2); rst = 1'b1; ticks(5);

    // 6b: saturation
    clr_cnt();
    g0 = goals_seen;
    for (int i = 0; i < 256; i++) begin set_blk(1); ticks(8); set_blk(0); ticks(20); end
    check_eq("t6_sat_goals", goals_seen - g0, 256);
    check_eq("t6_sat_cnt", goal_cnt, 255);

    // randomized traffic against the model
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 12);
      set_blk($urandom_range(0, 1) == 1);
      en = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        cnt_clr = ($urandom_range(0, 63) == 0);
        tick();
      end
      cnt_clr = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
